r2_column_buffer: RTL and testbench
===================================

Name: r2_column_buffer

Overview:
- Upstream neighbour of the R2 patch-sum stage: turns a raster pixel stream into the five vertically aligned taps S1..S5 that the R2 patch-sum stage consumes.
- One 5-tap column per accepted pixel.
- Holds the four previous image rows in circular line buffers.
- Zero-pads the top border, and optionally the bottom border, so that the 5x5 patch stage sees zeros outside the image.

Parameters:
COLS, 7, pixels per image row (>=5, <=1023)
ROWS, 7, rows per frame (>=5, <=1021)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; one clock, reset is synchronous and active-low
done_i  input  1  input pixel valid strobe; gaps allowed
data_i  input  8  input pixel, raster order
S1  output  8  tap, row r-4 (oldest)
S2  output  8  tap, row r-3
S3  output  8  tap, row r-2 (patch centre row)
S4  output  8  tap, row r-1
S5  output  8  tap, row r (current)
done_o  output  1  S1..S5 valid this cycle
progress_done_o  output  1  one-cycle pulse with the last column of a frame
busy_o  output  1  high from first accepted pixel until frame end

Behaviour:
- Reset (rst=0 at clk edge):
  - all outputs 0; col_cnt=0, row_cnt=0; FSM to IDLE.
  - Line-buffer RAM contents need not be cleared: masking covers them.
- Storage: 4 line buffers LB0..LB3, COLS x 8 each, addressed by col_cnt.
- On an accepted pixel at column c, in one cycle:
  - read taps: S5=data_i, S4=LB0[c], S3=LB1[c], S2=LB2[c], S1=LB3[c].
  - shift: LB3[c]<=LB2[c], LB2[c]<=LB1[c], LB1[c]<=LB0[c], LB0[c]<=data_i.
- Top masking (rows above the image read as 0):
  - S4=0 if row_cnt<1; S3=0 if row_cnt<2; S2=0 if row_cnt<3; S1=0 if row_cnt<4.
- Latency: outputs registered; done_o and taps appear exactly 1 cycle after the accepting done_i edge.
- done_o=1 only for accepted pixels with row_cnt>=2, i.e. centre row = row_cnt-2 is valid.
  - Rows 0 and 1 fill silently.
- Counters:
  - col_cnt wraps COLS-1->0 and increments row_cnt.
  - row_cnt is 10 bits.
- FSM:
  - IDLE: done_i -> FILL, busy_o=1.
  - FILL (row_cnt<2) -> STREAM when row_cnt reaches 2.
  - STREAM -> FLUSH, or DONE if the flush macro is absent, after pixel (ROWS-1, COLS-1) is accepted.
  - FLUSH -> DONE after the flush columns.
  - DONE: single cycle; clears counters and busy_o, then -> IDLE.
- progress_done_o coincides with done_o of the final output column of the frame.
- Without flush, the final column is pixel (ROWS-1, COLS-1).
- done_i while in FLUSH or DONE: ignored, pixel dropped, no counter change.
  - Upstream must wait for busy_o=0.
- done_i in IDLE with row_cnt=0: starts a new frame in the same cycle; no dead cycle.
- Reset mid-frame: immediate abort, no progress_done_o, next frame starts clean; stale RAM is masked.
- Back-to-back frames: allowed after DONE; the first pixel of the next frame may arrive the cycle after DONE.

Optional Feature:
- Macro R2_BOTTOM_FLUSH_EN.
- Defined:
  - after the last input pixel, FLUSH autonomously emits 2*COLS columns, one per cycle with no gaps, done_o=1 each.
  - Virtual row ROWS: S5=0.
  - Virtual row ROWS+1: S5=0, S4=0.
  - The remaining taps are read from the line buffers with the normal shift, giving centre rows ROWS-2 and ROWS-1.
  - Per frame: ROWS*COLS done_o pulses; progress_done_o on the last flush column.
- Undefined:
  - FLUSH state absent; (ROWS-2)*COLS done_o pulses per frame.
  - progress_done_o on the column of input pixel (ROWS-1, COLS-1).

Test Plan:
- Default params, pixel(r,c)=16r+c+1, continuous done_i -> 1 cycle after input (2,0): done_o=1, S5=0x21, S4=0x11, S3=0x01, S2=0, S1=0; no done_o during rows 0-1.
- Same stream -> 1 cycle after input (6,3): S5=0x64, S4=0x54, S3=0x44, S2=0x34, S1=0x24.
- Count over one frame -> 35 done_o pulses without R2_BOTTOM_FLUSH_EN, 49 with it; exactly one progress_done_o, aligned with the final done_o.
- Flush enabled, last flush column -> S5=0, S4=0, S3=0x67, S2=0x57, S1=0x47; busy_o drops after DONE.
- Random 0-3 cycle gaps on done_i -> identical tap sequence to the gapless run, each output exactly 1 cycle after its input.
- rst=0 for 1 cycle at pixel (4,2), then a full new frame -> no progress_done_o for the aborted frame; new frame output at (2,0) shows S2=S1=0 despite stale RAM.

Source files
------------

// File: rtl/r2_column_buffer.sv
// Raster pixel stream to five vertically aligned taps S1..S5 for the R2 patch-sum stage.
// Define R2_BOTTOM_FLUSH_EN to emit two zero-padded bottom rows after each frame.
module r2_column_buffer #(
  parameter int COLS = 7,
  parameter int ROWS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic [7:0] S3,
  output logic [7:0] S4,
  output logic [7:0] S5,
  output logic       done_o,
  output logic       progress_done_o,
  output logic       busy_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [9:0]    ROW_LAST = 10'(ROWS - 1);
`ifdef R2_BOTTOM_FLUSH_EN
  localparam logic [9:0]    ROW_FLUSH_LAST = 10'(ROWS + 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
`ifdef R2_BOTTOM_FLUSH_EN
    FLUSH,
`endif
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col_cnt;
  logic [9:0]      row_cnt;
  logic [7:0]      lb0 [COLS];
  logic [7:0]      lb1 [COLS];
  logic [7:0]      lb2 [COLS];
  logic [7:0]      lb3 [COLS];
  logic            accept, flush_step, step, last_out, bot_mask;
  logic            col_last, frame_last;
  logic [7:0]      pix, t1, t2, t3, t4;

  assign col_last   = (col_cnt == COL_LAST);
  assign frame_last = col_last && (row_cnt == ROW_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    flush_step = 1'b0;
    last_out   = 1'b0;
    bot_mask   = 1'b0;
    case (state)
      IDLE: begin
        if (done_i) begin
          accept    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (done_i) begin
          accept = 1'b1;
          if (col_last && row_cnt == 10'd1) state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (done_i) begin
          accept = 1'b1;
          if (frame_last) begin
`ifdef R2_BOTTOM_FLUSH_EN
            state_nxt = FLUSH;
`else
            state_nxt = DONE;
            last_out  = 1'b1;
`endif
          end
        end
      end
`ifdef R2_BOTTOM_FLUSH_EN
      FLUSH: begin
        flush_step = 1'b1;
        // Second virtual row also forces S4: LB0 would hold the zero of the first one anyway
        bot_mask   = (row_cnt == ROW_FLUSH_LAST);
        if (col_last && row_cnt == ROW_FLUSH_LAST) begin
          state_nxt = DONE;
          last_out  = 1'b1;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    step = accept | flush_step;
    pix  = flush_step ? '0 : data_i;
    t4   = (row_cnt < 10'd1 || bot_mask) ? '0 : lb0[col_cnt];
    t3   = (row_cnt < 10'd2) ? '0 : lb1[col_cnt];
    t2   = (row_cnt < 10'd3) ? '0 : lb2[col_cnt];
    t1   = (row_cnt < 10'd4) ? '0 : lb3[col_cnt];
  end

  // Line buffers: no reset, stale contents are hidden by the row masks above
  always_ff @(posedge clk) begin
    if (step) begin
      lb0[col_cnt] <= pix;
      lb1[col_cnt] <= lb0[col_cnt];
      lb2[col_cnt] <= lb1[col_cnt];
      lb3[col_cnt] <= lb2[col_cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt         <= '0;
      row_cnt         <= '0;
      S1              <= '0;
      S2              <= '0;
      S3              <= '0;
      S4              <= '0;
      S5              <= '0;
      done_o          <= 1'b0;
      progress_done_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      done_o          <= step && (row_cnt >= 10'd2);
      progress_done_o <= last_out;
      if (step) begin
        S5 <= pix;
        S4 <= t4;
        S3 <= t3;
        S2 <= t2;
        S1 <= t1;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 10'd1;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (state == DONE) begin
        col_cnt <= '0;
        row_cnt <= '0;
        busy_o  <= 1'b0;
      end else if (accept) begin
        busy_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_r2_column_buffer.sv
// Self-checking bench for r2_column_buffer: random and patterned frames against an image-array model.
module tb_r2_column_buffer;

  localparam int COLS = 7;
  localparam int ROWS = 7;
`ifdef R2_BOTTOM_FLUSH_EN
  localparam int R_END = ROWS + 2;
`else
  localparam int R_END = ROWS;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] S1, S2, S3, S4, S5;
  logic       done_o, progress_done_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  img     [ROWS][COLS];
  logic [39:0] cap     [ROWS+2][COLS];
  logic [39:0] gapless [ROWS+2][COLS];

  r2_column_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .done_o(done_o), .progress_done_o(progress_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Column of the 5x5 window ending at image row r; rows outside the image are zero.
  function automatic logic [39:0] exp_taps(int r, int c);
    logic [39:0] e;
    int rr;
    e = '0;
    for (int k = 0; k < 5; k++) begin
      rr = r - k;
      e[8*k +: 8] = (rr < 0 || rr >= ROWS) ? 8'h00 : img[rr][c];
    end
    return e;
  endfunction

  task automatic run_frame(input int max_gap, input bit patterned,
                           input int abort_r, input int abort_c);
    int          n_done = 0;
    int          n_prog = 0;
    logic        exp_done, exp_prog;
    logic [39:0] e, got;
    for (int r = 0; r < R_END; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r < ROWS) begin
          repeat ($urandom_range(max_gap, 0)) begin
            done_i = 1'b0;
            data_i = 8'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (done_o !== 1'b0 || progress_done_o !== 1'b0) begin
              n_err++;
              $display("FAIL gap_idle r%0d c%0d: done_o=%b progress=%b, want 0 0",
                       r, c, done_o, progress_done_o);
            end
          end
          img[r][c] = patterned ? 8'(16*r + c + 1) : 8'($urandom);
          done_i = 1'b1;
          data_i = img[r][c];
        end else begin
          done_i = 1'($urandom);
          data_i = 8'($urandom);
        end
        @(posedge clk); #1;
        exp_done = (r >= 2);
        exp_prog = (r == R_END - 1) && (c == COLS - 1);
        got = {S1, S2, S3, S4, S5};
        cap[r][c] = got;
        e = exp_taps(r, c);
        n_cmp++;
        if (done_o !== exp_done || progress_done_o !== exp_prog || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL ctrl r%0d c%0d: done/prog/busy=%b%b%b, want %b%b1",
                   r, c, done_o, progress_done_o, busy_o, exp_done, exp_prog);
        end
        if (exp_done) begin
          n_cmp++;
          if (got !== e) begin
            n_err++;
            $display("FAIL taps r%0d c%0d: S1..S5=%h, want %h", r, c, got, e);
          end
        end
        n_done += int'(done_o);
        n_prog += int'(progress_done_o);
        if (r == abort_r && c == abort_c) begin
          rst    = 1'b0;
          done_i = 1'b0;
          @(posedge clk); #1;
          rst = 1'b1;
          n_cmp++;
          if ({S1, S2, S3, S4, S5, done_o, progress_done_o, busy_o} !== '0) begin
            n_err++;
            $display("FAIL abort_reset: outputs=%h/%b%b%b, want all 0",
                     {S1, S2, S3, S4, S5}, done_o, progress_done_o, busy_o);
          end
          return;
        end
      end
    end
    // DONE cycle: a pixel offered here must be dropped
    done_i = 1'b1;
    data_i = 8'($urandom);
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || progress_done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL frame_end: done/prog/busy=%b%b%b, want 000",
               done_o, progress_done_o, busy_o);
    end
    n_cmp++;
    if (n_done !== (R_END - 2) * COLS || n_prog !== 1) begin
      n_err++;
      $display("FAIL frame_counts: done_o=%0d progress=%0d, want %0d 1",
               n_done, n_prog, (R_END - 2) * COLS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      done_i = 1'b1;
      data_i = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({S1, S2, S3, S4, S5, done_o, progress_done_o, busy_o} !== '0) begin
        n_err++;
        $display("FAIL reset_state: outputs=%h/%b%b%b, want all 0",
                 {S1, S2, S3, S4, S5}, done_o, progress_done_o, busy_o);
      end
    end
    rst    = 1'b1;
    done_i = 1'b0;
  endtask

  task automatic test_pattern();
    run_frame(0, 1'b1, -1, -1);
    n_cmp++;
    if (cap[2][0] !== 40'h00_00_01_11_21) begin
      n_err++;
      $display("FAIL first_output: S1..S5=%h, want 0000011121", cap[2][0]);
    end
    n_cmp++;
    if (cap[6][3] !== 40'h24_34_44_54_64) begin
      n_err++;
      $display("FAIL mid_output: S1..S5=%h, want 2434445464", cap[6][3]);
    end
`ifdef R2_BOTTOM_FLUSH_EN
    n_cmp++;
    if (cap[ROWS+1][COLS-1] !== 40'h47_57_67_00_00) begin
      n_err++;
      $display("FAIL last_flush: S1..S5=%h, want 4757670000", cap[ROWS+1][COLS-1]);
    end
`endif
    gapless = cap;
  endtask

  task automatic test_gaps();
    run_frame(3, 1'b1, -1, -1);
    for (int r = 2; r < R_END; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n_cmp++;
        if (cap[r][c] !== gapless[r][c]) begin
          n_err++;
          $display("FAIL gap_vs_gapless r%0d c%0d: %h, want %h", r, c, cap[r][c], gapless[r][c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) run_frame(int'($urandom_range(2, 0)), 1'b0, -1, -1);
  endtask

  task automatic test_abort();
    run_frame(1, 1'b0, 4, 2);
    run_frame(0, 1'b0, -1, -1);
    n_cmp++;
    if (cap[2][0][39:24] !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_masking: S1,S2=%h, want 0000", cap[2][0][39:24]);
    end
  endtask

  initial begin
    rst    = 1'b0;
    done_i = 1'b0;
    data_i = '0;
    test_reset();
    test_pattern();
    test_gaps();
    test_back_to_back();
    test_abort();
    done_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
